// File: rtl/bopit_round_controller.sv
// Bop-It round controller: prompts one of 15 actions from an LFSR, times the
// player's response per tick, and tracks current, last and high scores.
module bopit_round_controller #(
  parameter int TIMEOUT_INIT = 12,
  parameter int TIMEOUT_MIN  = 4,
  parameter int SCORE_MAX    = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start,
  input  logic [10:0] sw,
  input  logic [3:0]  btn,
  input  logic        hard,
  output logic [3:0]  action,
  output logic [15:0] led,
  output logic [2:0]  letter,
  output logic        busy,
  output logic        game_over,
  output logic [6:0]  score,
  output logic [6:0]  last_score,
  output logic [6:0]  high_score
);

  localparam int CW = $clog2(TIMEOUT_INIT + 1);

  typedef enum logic [1:0] {IDLE, ARM, WAIT, OVER} state_t;

  state_t        state, state_next;
  logic [3:0]    lfsr, prev_action, pick;
  logic [CW-1:0] cnt, window, window_next;
  logic [14:0]   resp;
  logic          correct, load, score_inc, end_game, clear_score;
  int            w;

  // Expected {btn,sw} one-hot for an action code; btnL sits at bit 14.
  function automatic logic [14:0] code_bits(input logic [3:0] c);
    code_bits = '0;
    case (c)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
      4'd6, 4'd7, 4'd8, 4'd9: code_bits[c - 4'd1] = 1'b1;
      4'd10: code_bits[14] = 1'b1;
      4'd11: code_bits[13] = 1'b1;
      4'd12: code_bits[12] = 1'b1;
      4'd13: code_bits[11] = 1'b1;
      4'd14: code_bits[9]  = 1'b1;
      4'd15: code_bits[10] = 1'b1;
      default: code_bits = '0;
    endcase
  endfunction

  function automatic logic [15:0] led_of(input logic [3:0] c);
    led_of = '0;
    case (c)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
      4'd6, 4'd7, 4'd8, 4'd9: led_of[c - 4'd1] = 1'b1;
      4'd14: led_of[9]  = 1'b1;
      4'd15: led_of[10] = 1'b1;
      default: led_of = '0;
    endcase
  endfunction

  function automatic logic [2:0] letter_of(input logic [3:0] c);
    if (c >= 4'd10 && c <= 4'd13) letter_of = 3'(c - 4'd9);
    else                          letter_of = '0;
  endfunction

  assign resp      = {btn, sw};
  assign correct   = (resp == code_bits(action));
  assign busy      = (state == WAIT);
  assign game_over = (state == OVER);

  always_comb begin
    pick = lfsr;
    if (lfsr == prev_action) pick = (prev_action == 4'd15) ? 4'd1 : prev_action + 4'd1;
    w = TIMEOUT_INIT;
    if (hard) begin
      w = TIMEOUT_INIT - int'(score[6:3]);
      if (w < TIMEOUT_MIN) w = TIMEOUT_MIN;
    end
    window_next = CW'(w);
  end

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    score_inc   = 1'b0;
    end_game    = 1'b0;
    clear_score = 1'b0;
    case (state)
      IDLE: if (start) state_next = ARM;
      ARM: begin
        if (tick && resp == '0) begin
          state_next = WAIT;
          load       = 1'b1;
        end
      end
      WAIT: begin
        // A correct answer beats a timeout landing on the same tick.
        if (tick) begin
          if (correct) begin
            state_next = ARM;
            score_inc  = 1'b1;
          end else if ((resp != '0 && cnt != '0) || cnt == window - CW'(1)) begin
            state_next = OVER;
            end_game   = 1'b1;
          end
        end
      end
      OVER: begin
        if (start) begin
          state_next  = ARM;
          clear_score = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr        <= 4'b0001;
      prev_action <= '0;
      action      <= '0;
      led         <= '0;
      letter      <= '0;
      cnt         <= '0;
      window      <= '0;
      score       <= '0;
      last_score  <= '0;
      high_score  <= '0;
    end else begin
      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      if (load) begin
        action      <= pick;
        prev_action <= pick;
        led         <= led_of(pick);
        letter      <= letter_of(pick);
        window      <= window_next;
        cnt         <= '0;
      end else if (state == WAIT && tick) begin
        if (state_next == WAIT) begin
          cnt <= cnt + CW'(1);
        end else begin
          action <= '0;
          led    <= '0;
          letter <= '0;
        end
      end
      if (score_inc && score != 7'(SCORE_MAX)) score <= score + 7'd1;
      if (end_game) begin
        last_score <= score;
        if (score > high_score) high_score <= score;
      end
      if (clear_score) score <= '0;
    end
  end

endmodule

// File: tb/tb_bopit_round_controller.sv
// Directed bench for bopit_round_controller with a per-cycle behavioural model.
module tb_bopit_round_controller;

  localparam int T_INIT = 12;
  localparam int T_MIN  = 4;
  localparam int S_MAX  = 99;
  localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_OVER = 3;

  logic        clk = 1'b0, rst_n = 1'b1, tick = 1'b0, start = 1'b0, hard = 1'b0;
  logic [10:0] sw = '0;
  logic [3:0]  btn = '0;
  logic [3:0]  action;
  logic [15:0] led;
  logic [2:0]  letter;
  logic        busy, game_over;
  logic [6:0]  score, last_score, high_score;

  int vectors = 0, miscompares = 0;

  // Successive states of the x^4+x^3+1 sequence starting from 1.
  int lfsr_seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

  int m_phase = P_IDLE, m_edges = 0, m_action = 0, m_prev = 0, m_window = 0;
  int m_ticks = 0, m_score = 0, m_last = 0, m_high = 0;

  bopit_round_controller #(.TIMEOUT_INIT(T_INIT), .TIMEOUT_MIN(T_MIN), .SCORE_MAX(S_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .sw(sw), .btn(btn), .hard(hard),
    .action(action), .led(led), .letter(letter), .busy(busy), .game_over(game_over),
    .score(score), .last_score(last_score), .high_score(high_score)
  );

  always #5 clk = ~clk;

  function automatic int in_bits(input int c);
    if (c >= 1 && c <= 9) return 1 << (c - 1);
    if (c >= 14)          return 1 << (c - 5);
    if (c >= 10)          return 1 << (24 - c);
    return 0;
  endfunction

  function automatic int led_of(input int c);
    if (c >= 1 && c <= 9) return 1 << (c - 1);
    if (c >= 14)          return 1 << (c - 5);
    return 0;
  endfunction

  function automatic int letter_of(input int c);
    return (c >= 10 && c <= 13) ? c - 9 : 0;
  endfunction

  function automatic int next_pick();
    int v;
    v = lfsr_seq[m_edges % 15];
    if (v == m_prev) return (m_prev == 15) ? 1 : m_prev + 1;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int resp, pick, w;
    if (!rst_n) begin
      m_phase = P_IDLE; m_edges = 0; m_action = 0; m_prev = 0; m_window = 0;
      m_ticks = 0; m_score = 0; m_last = 0; m_high = 0;
    end else begin
      resp = int'({btn, sw});
      pick = next_pick();
      m_edges++;
      case (m_phase)
        P_IDLE: if (start) m_phase = P_ARM;
        P_ARM: if (tick && resp == 0) begin
          m_action = pick; m_prev = pick; m_ticks = 0;
          w = hard ? T_INIT - m_score / 8 : T_INIT;
          m_window = (w < T_MIN && hard) ? T_MIN : w;
          m_phase = P_WAIT;
        end
        P_WAIT: if (tick) begin
          if (resp == in_bits(m_action)) begin
            m_score = (m_score >= S_MAX) ? S_MAX : m_score + 1;
            m_phase = P_ARM;
          end else if ((resp != 0 && m_ticks >= 1) || m_ticks + 1 == m_window) begin
            m_last = m_score;
            if (m_score > m_high) m_high = m_score;
            m_phase = P_OVER;
          end else m_ticks++;
        end
        P_OVER: if (start) begin m_score = 0; m_phase = P_ARM; end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    int ea, el, et;
    ea = (m_phase == P_WAIT) ? m_action : 0;
    el = led_of(ea);
    et = letter_of(ea);
    vectors++;
    if (int'(action) != ea || int'(led) != el || int'(letter) != et ||
        busy != (m_phase == P_WAIT) || game_over != (m_phase == P_OVER) ||
        int'(score) != m_score || int'(last_score) != m_last || int'(high_score) != m_high) begin
      miscompares++;
      $display("FAIL cycle t=%0t got act=%0d led=%h let=%0d busy=%0b over=%0b sc=%0d last=%0d hi=%0d want act=%0d led=%h let=%0d busy=%0b over=%0b sc=%0d last=%0d hi=%0d",
               $time, action, led, letter, busy, game_over, score, last_score, high_score,
               ea, el, et, m_phase == P_WAIT, m_phase == P_OVER, m_score, m_last, m_high);
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int bits);
    {btn, sw} = 15'(bits);
    tick = 1'b1;
    step();
    {btn, sw} = '0;
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic go_wait(input int code);
    int found;
    if (code != 0) begin
      found = 0;
      for (int i = 0; i < 40; i++) begin
        if (next_pick() == code) begin found = 1; break; end
        step();
      end
      check("reach_action", found, 1);
    end
    do_tick(0);
  endtask

  task automatic correct_resp();
    do_tick(in_bits(m_action));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_score", score, 0);
    check("reset_action", action, 0);

    pulse_start();
    check("arm_busy", busy, 0);
    go_wait(0);
    check("wait_busy", busy, 1);
    check("first_action_range", int'(action >= 1 && action <= 15), 1);
    check("first_score", score, 0);
    do_tick(0);
    correct_resp();
    check("score_after_first", score, 1);

    go_wait((m_prev == 1) ? 2 : 1);
    correct_resp();
    go_wait(4);
    check("action4", action, 4);
    check("led_action4", led, 16'h0008);
    do_tick(0);
    do_tick(15'h008);
    check("score_after_sw3", score, 3);
    do_tick(15'h008);
    check("arm_held_by_sw", busy, 0);
    go_wait(7);
    check("new_action_not4", int'(action != 4), 1);
    check("action7", action, 7);
    correct_resp();

    go_wait(10);
    check("letter_L", letter, 1);
    check("led_button", led, 0);
    do_tick(15'h1000);
    check("grace_first_tick", busy, 1);
    do_tick(15'h1000);
    check("wrong_over", game_over, 1);
    check("wrong_last", last_score, 4);
    check("wrong_high", high_score, 4);
    check("over_letter", letter, 0);

    pulse_start();
    check("restart_score", score, 0);
    check("restart_last", last_score, 4);
    for (int r = 0; r < 64; r++) begin go_wait(0); correct_resp(); end
    check("score64", score, 64);
    hard = 1'b1;
    go_wait(0);
    hard = 1'b0;
    repeat (3) do_tick(0);
    check("hard_tick3_busy", busy, 1);
    do_tick(0);
    check("hard_timeout_over", game_over, 1);
    check("hard_last", last_score, 64);

    pulse_start();
    go_wait(0);
    repeat (T_INIT - 1) do_tick(0);
    check("soft_tick11_busy", busy, 1);
    do_tick(0);
    check("soft_timeout_over", game_over, 1);
    check("soft_high", high_score, 64);

    pulse_start();
    for (int r = 0; r < 99; r++) begin go_wait(0); correct_resp(); end
    check("score99", score, 99);
    go_wait(0);
    correct_resp();
    check("score_saturated", score, 99);
    go_wait(0);
    do_tick(0);
    do_tick(15'h7FFF);
    check("high99", high_score, 99);
    pulse_start();
    check("clear_after_99", score, 0);
    check("high_retained", high_score, 99);

    go_wait(0);
    do_tick(0);
    #3 rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_action", action, 0);
    check("async_led", led, 0);
    check("async_high", high_score, 0);
    check("async_last", last_score, 0);
    step();
    step();
    #2 rst_n = 1'b1;
    repeat (3) do_tick(0);
    check("idle_after_reset", busy, 0);
    check("idle_not_over", game_over, 0);
    pulse_start();
    go_wait(0);
    check("wait_after_reset", busy, 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
